// File: rtl/seq_detect_scheduler_pkg.sv
// Shared definitions for the sequence-detector scheduler: FSM state
// encoding, default detector constants and the arbitration helper.
package seq_detect_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CLEAR  = 2'd1,
    ST_SHIFT  = 2'd2,
    ST_REPORT = 2'd3
  } state_t;

  localparam int         DEF_WORD_W  = 8;
  localparam int         DEF_PAT_LEN = 4;
  localparam logic [3:0] DEF_PATTERN = 4'b1101;
  localparam int         DEF_CNT_W   = 4;

  // Winner among the two requesters: a lone requester always wins, a tie
  // goes to the requester that was not served last.
  function automatic logic pick_id(input logic v0, input logic v1, input logic last_id);
    if (v0 && v1) begin
      return ~last_id;
    end else if (v1) begin
      return 1'b1;
    end else begin
      return 1'b0;
    end
  endfunction

endpackage

// File: rtl/seq_detect_scheduler_if.sv
// Requester handshakes, status and result signals of the scheduler.
// master = requester/consumer side, slave = scheduler side.
interface seq_detect_scheduler_if
  import seq_detect_scheduler_pkg::*;
#(
  parameter int WORD_W = DEF_WORD_W,
  parameter int CNT_W  = DEF_CNT_W
);

  logic              req0_valid;
  logic [WORD_W-1:0] req0_word;
  logic              req0_ready;
  logic              req1_valid;
  logic [WORD_W-1:0] req1_word;
  logic              req1_ready;
  logic              busy;
  logic              grant_id;
  logic              det_j;
  logic              det_w;
  logic              done_valid;
  logic              done_id;
  logic [CNT_W-1:0]  done_hits;

  modport master (
    output req0_valid, req0_word, req1_valid, req1_word,
    input  req0_ready, req1_ready, busy, grant_id, det_j, det_w,
           done_valid, done_id, done_hits
  );

  modport slave (
    input  req0_valid, req0_word, req1_valid, req1_word,
    output req0_ready, req1_ready, busy, grant_id, det_j, det_w,
           done_valid, done_id, done_hits
  );

endinterface

// File: rtl/seq_detect_scheduler_core.sv
// Serial pattern detector: keeps the last PAT_LEN-1 input bits and flags
// (Mealy) when they, followed by the current bit, equal PATTERN.
module seq_detect_core
  import seq_detect_scheduler_pkg::*;
#(
  parameter int                 PAT_LEN = DEF_PAT_LEN,
  parameter logic [PAT_LEN-1:0] PATTERN = DEF_PATTERN
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic j,
  output logic w
);

  localparam int HIST_W = PAT_LEN - 1;

  logic [HIST_W-1:0] hist_reg;
  logic [HIST_W-1:0] hist_next;

  // Bit 0 takes the newest input; older bits move up. clr empties history
  // so a match can never straddle two words.
  for (genvar gi = 0; gi < HIST_W; gi++) begin : g_hist
    if (gi == 0) begin : g_first
      assign hist_next[gi] = clr ? 1'b0 : j;
    end else begin : g_rest
      assign hist_next[gi] = clr ? 1'b0 : hist_reg[gi-1];
    end
  end

  // History register, zero after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hist_reg <= '0;
    end else begin
      hist_reg <= hist_next;
    end
  end

  assign w = ({hist_reg, j} == PATTERN);

endmodule

// File: rtl/seq_detect_scheduler.sv
// Shares one serial sequence detector between two word requesters:
// round-robin accept, clear, shift MSB-first, report the hit count.
module seq_detect_scheduler
  import seq_detect_scheduler_pkg::*;
#(
  parameter int                 WORD_W  = DEF_WORD_W,
  parameter int                 PAT_LEN = DEF_PAT_LEN,
  parameter logic [PAT_LEN-1:0] PATTERN = DEF_PATTERN,
  parameter int                 CNT_W   = DEF_CNT_W
) (
  input  logic                   clk,
  input  logic                   rst,
  seq_detect_scheduler_if.slave  bus
);

  localparam int              BIT_W    = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WORD_W - 1);

  state_t            state_reg, state_next;
  logic              last_id_reg, last_id_next;
  logic              grant_id_reg, grant_id_next;
  logic [WORD_W-1:0] word_reg, word_next;
  logic [BIT_W-1:0]  bit_cnt_reg, bit_cnt_next;
  logic [CNT_W-1:0]  hits_reg, hits_next;

  logic win_id;
  logic ready0;
  logic ready1;
  logic det_clr;
  logic in_shift;
  logic det_j;
  logic core_w;
  logic det_w;

  assign in_shift = (state_reg == ST_SHIFT);
  assign det_j    = in_shift & word_reg[WORD_W-1];
  assign det_w    = in_shift & core_w;

  seq_detect_core #(
    .PAT_LEN (PAT_LEN),
    .PATTERN (PATTERN)
  ) u_core (
    .clk (clk),
    .rst (rst),
    .clr (det_clr),
    .j   (det_j),
    .w   (core_w)
  );

  // State and datapath registers; last_id starts at 1 so req0 wins the first tie.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= ST_IDLE;
      last_id_reg  <= 1'b1;
      grant_id_reg <= 1'b0;
      word_reg     <= '0;
      bit_cnt_reg  <= '0;
      hits_reg     <= '0;
    end else begin
      state_reg    <= state_next;
      last_id_reg  <= last_id_next;
      grant_id_reg <= grant_id_next;
      word_reg     <= word_next;
      bit_cnt_reg  <= bit_cnt_next;
      hits_reg     <= hits_next;
    end
  end

  // Next-state logic, arbitration and serial datapath control.
  always_comb begin
    state_next    = state_reg;
    last_id_next  = last_id_reg;
    grant_id_next = grant_id_reg;
    word_next     = word_reg;
    bit_cnt_next  = bit_cnt_reg;
    hits_next     = hits_reg;
    ready0        = 1'b0;
    ready1        = 1'b0;
    det_clr       = 1'b0;
    win_id        = pick_id(bus.req0_valid, bus.req1_valid, last_id_reg);

    case (state_reg)
      ST_IDLE: begin
        if (bus.req0_valid || bus.req1_valid) begin
          ready0        = ~win_id;
          ready1        = win_id;
          word_next     = win_id ? bus.req1_word : bus.req0_word;
          grant_id_next = win_id;
          last_id_next  = win_id;
          state_next    = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        det_clr      = 1'b1;
        hits_next    = '0;
        bit_cnt_next = '0;
        state_next   = ST_SHIFT;
      end
      ST_SHIFT: begin
        word_next    = {word_reg[WORD_W-2:0], 1'b0};
        bit_cnt_next = bit_cnt_reg + BIT_W'(1);
        if (det_w) begin
          hits_next = hits_reg + CNT_W'(1);
        end
        if (bit_cnt_reg == LAST_BIT) begin
          state_next = ST_REPORT;
        end
      end
      ST_REPORT: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Ready is masked while reset is held so every output reads 0 in reset.
  assign bus.req0_ready = ready0 & rst;
  assign bus.req1_ready = ready1 & rst;
  assign bus.busy       = (state_reg != ST_IDLE);
  assign bus.grant_id   = grant_id_reg;
  assign bus.det_j      = det_j;
  assign bus.det_w      = det_w;
  assign bus.done_valid = (state_reg == ST_REPORT);
  assign bus.done_id    = (state_reg == ST_REPORT) & grant_id_reg;
  assign bus.done_hits  = (state_reg == ST_REPORT) ? hits_reg : '0;

endmodule
